cai_submit_sched: RTL and testbench
===================================

Name: cai_submit_sched

Overview:
- Round-robin scheduler that shares one CAI submit channel (descriptor base, ring mask, context select, submit doorbell) between NREQ requesters, e.g. host core, DMA and debug.
- Exactly one job is in flight at a time. The scheduler drives the submit doorbell, waits for the completion doorbell, checks the returned tag and hands status back to the granted requester.
- Sits in the system top between the requesters and the CAI device register inputs, replacing direct host writes to those registers.

Parameters:
- NREQ, 2, number of requesters (1..8).
- TIMEOUT_CYC, 20000, cycles allowed in WAIT before a job is aborted.
- RING_MASK, 0, submit ring mask driven to the device (ring depth = RING_MASK+1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester job request.
- req_ready  out  NREQ  one-hot; high for one cycle when that requester's job is accepted.
- req_desc_base  in  NREQ*64  submit descriptor ring base per requester.
- req_context  in  NREQ*16  context id per requester.
- req_tag  in  NREQ*32  tag expected back in the completion record.
- submit_desc_base  out  64  to CAI device.
- submit_ring_mask  out  32  to CAI device.
- context_sel  out  16  to CAI device.
- submit_doorbell  out  1  one-cycle pulse.
- dev_ready  in  1  CAI status[0].
- comp_doorbell  in  1  completion strobe from the device.
- comp_tag  in  32  decoded completion tag.
- comp_status  in  16  decoded completion status.
- resp_valid  out  NREQ  one-hot, one-cycle response pulse.
- resp_status  out  16  status for resp_valid.
- busy  out  1  high in any state other than IDLE.
- submit_idx  out  32  running submit count; ring slot = submit_idx & RING_MASK.

Behaviour:
Reset (asynchronous, rst_n low):
- State = IDLE. All outputs 0, except submit_ring_mask = RING_MASK.
- Round-robin pointer = 0, timeout counter = 0, submit_idx = 0.
- An in-flight job is dropped silently. No resp_valid is issued for it.

FSM states: IDLE, SETUP, RING, WAIT, RESP.
- IDLE:
  - Waits for dev_ready=1 and any req_valid.
  - Grant goes to the lowest index at or above the pointer, wrapping.
  - Latches that requester's base, context and tag; pulses req_ready[g]; goes to SETUP.
  - Pointer becomes g+1 mod NREQ.
- SETUP (1 cycle):
  - submit_desc_base and context_sel show the latched values.
  - These stay stable from SETUP until RESP exits.
- RING (1 cycle):
  - submit_doorbell=1. Counter cleared. Goes to WAIT.
- WAIT:
  - The counter increments each cycle.
  - comp_doorbell=1 while in WAIT leads to RESP.
    - If comp_tag == latched tag, resp_status = comp_status.
    - Otherwise resp_status = 16'hFFFE (TAG_MISMATCH).
  - If the counter reaches TIMEOUT_CYC-1 without comp_doorbell, goes to RESP with resp_status = 16'hFFFF (TIMEOUT).
  - If comp_doorbell and the timeout occur in the same cycle, the completion wins.
- RESP (1 cycle):
  - resp_valid[g]=1. submit_idx increments, wrapping at 2^32. Goes to IDLE.
  - After RESP, submit_desc_base and context_sel hold their values; they are not cleared.

Timing and boundary rules:
- Latency: req_ready occurs in the cycle IDLE accepts the request. The doorbell is asserted 2 cycles after the accept cycle. resp_valid is asserted 1 cycle after comp_doorbell is sampled.
- comp_doorbell outside WAIT is ignored.
- A requester that drops req_valid before the grant is skipped.
- req_valid held through RESP is re-arbitrated against the others in the next IDLE. Back-to-back grants to different requesters are possible with no idle bubble beyond IDLE.
- A requester must not change its inputs while req_valid is high.
- If dev_ready falls mid-job, the job continues; dev_ready gates only new grants.

Decomposition:
- Shared package (carbon_arch_pkg or a CAI package), to hold:
  - status codes CAI_SCHED_STATUS_TIMEOUT=16'hFFFF and CAI_SCHED_STATUS_TAG_MISMATCH=16'hFFFE;
  - the FSM state enum typedef.
- One natural sub-module: carbon_rr_arbiter.
  - Parameter N.
  - Inputs: req, ptr. Output: one-hot grant.
  - Combinational, reusable by other arbiters.

Test Plan:
- Single job, NREQ=2:
  - Stimulus: req0 with tag=1, base=0x2000, context=0. Model asserts comp_doorbell 10 cycles after the doorbell, with tag 1 and status 0.
  - Required: exactly one doorbell pulse, resp_valid=01, resp_status=0, submit_idx=1.
- Fairness:
  - Stimulus: req0 and req1 held continuously.
  - Required: grant order 0,1,0,1 over 4 jobs; context_sel follows each requester.
- Tag mismatch:
  - Stimulus: completion returns tag 5 against expected 6.
  - Required: resp_status=16'hFFFE; the next job proceeds normally.
- Timeout:
  - Stimulus: TIMEOUT_CYC=50, no completion.
  - Required: resp_valid exactly 50 cycles after the doorbell cycle, resp_status=16'hFFFF. A late comp_doorbell that arrives in IDLE is ignored.
- Gating and reset:
  - Stimulus: dev_ready=0 with req_valid=1 → no grant for 100 cycles. Then raise dev_ready and assert rst_n low during WAIT.
  - Required: all outputs go to their reset values immediately, no resp_valid, submit_idx=0.
- Simultaneous completion and timeout:
  - Stimulus: comp_doorbell on the final WAIT cycle.
  - Required: resp_status = comp_status, not TIMEOUT.

Source files
------------

// File: rtl/cai_submit_sched_pkg.sv
// cai_submit_sched_pkg: shared status codes and FSM state type for the CAI submit scheduler
package cai_submit_sched_pkg;

   localparam logic [15:0] CAI_SCHED_STATUS_TIMEOUT      = 16'hFFFF;
   localparam logic [15:0] CAI_SCHED_STATUS_TAG_MISMATCH = 16'hFFFE;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_RING,
      ST_WAIT,
      ST_RESP
   } sched_state_t;

endpackage

// File: rtl/carbon_rr_arbiter.sv
// carbon_rr_arbiter: combinational round-robin arbiter, lowest request at or above ptr wins, wrapping
module carbon_rr_arbiter #(
   parameter int N = 2
) (
   input  logic [N-1:0]                        req,
   input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
   output logic [N-1:0]                        grant
);

   logic [N-1:0] w_rot;
   logic [N-1:0] w_pri;

   // rotate so ptr sits at bit 0, pick the lowest set bit, rotate back
   assign w_rot = N'({req, req} >> ptr);
   assign w_pri = w_rot & (~w_rot + N'(1));
   assign grant = N'(({w_pri, w_pri} << ptr) >> N);

endmodule

// File: rtl/cai_submit_sched.sv
// cai_submit_sched: round-robin sharing of one CAI submit channel, one job in flight,
// with completion tag check and timeout
module cai_submit_sched
   import cai_submit_sched_pkg::*;
#(
   parameter int          NREQ        = 2,
   parameter int          TIMEOUT_CYC = 20000,
   parameter logic [31:0] RING_MASK   = 32'd0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*64-1:0] req_desc_base,
   input  logic [NREQ*16-1:0] req_context,
   input  logic [NREQ*32-1:0] req_tag,
   output logic [63:0]        submit_desc_base,
   output logic [31:0]        submit_ring_mask,
   output logic [15:0]        context_sel,
   output logic               submit_doorbell,
   input  logic               dev_ready,
   input  logic               comp_doorbell,
   input  logic [31:0]        comp_tag,
   input  logic [15:0]        comp_status,
   output logic [NREQ-1:0]    resp_valid,
   output logic [15:0]        resp_status,
   output logic               busy,
   output logic [31:0]        submit_idx
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   // counter value on the last WAIT cycle, so RESP lands TIMEOUT_CYC cycles after the doorbell
   localparam logic [31:0] TO_LAST = (TIMEOUT_CYC > 1) ? 32'(TIMEOUT_CYC - 2) : 32'd0;

   sched_state_t    r_state, w_next;
   logic [PW-1:0]   r_ptr, w_nptr;
   logic [NREQ-1:0] r_gnt, w_gnt;
   logic [63:0]     r_base, w_base;
   logic [15:0]     r_ctx, w_ctx;
   logic [31:0]     r_tag, w_tag;
   logic [31:0]     r_cnt;
   logic [31:0]     r_idx;
   logic [15:0]     r_status, w_status;
   logic            w_accept;
   logic            w_to;

   carbon_rr_arbiter #(.N(NREQ)) u_arb (
      .req   (req_valid),
      .ptr   (r_ptr),
      .grant (w_gnt)
   );

   always_comb begin
      w_base = '0;
      w_ctx  = '0;
      w_tag  = '0;
      w_nptr = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt[i]) begin
            w_base = req_desc_base[i*64 +: 64];
            w_ctx  = req_context[i*16 +: 16];
            w_tag  = req_tag[i*32 +: 32];
            w_nptr = PW'((i + 1) % NREQ);
         end
      end
   end

   assign w_to = r_cnt >= TO_LAST;

   always_comb begin
      w_next   = r_state;
      w_status = r_status;
      w_accept = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (dev_ready && |req_valid) begin
               w_next   = ST_SETUP;
               w_accept = 1'b1;
            end
         end
         ST_SETUP: w_next = ST_RING;
         ST_RING:  w_next = ST_WAIT;
         ST_WAIT: begin
            if (comp_doorbell) begin
               w_next   = ST_RESP;
               w_status = (comp_tag == r_tag) ? comp_status : CAI_SCHED_STATUS_TAG_MISMATCH;
            end else if (w_to) begin
               w_next   = ST_RESP;
               w_status = CAI_SCHED_STATUS_TIMEOUT;
            end
         end
         ST_RESP:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_ptr    <= '0;
         r_gnt    <= '0;
         r_base   <= '0;
         r_ctx    <= '0;
         r_tag    <= '0;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_status <= '0;
      end else begin
         r_state  <= w_next;
         r_status <= w_status;
         r_cnt    <= (r_state == ST_WAIT) ? r_cnt + 32'd1 : '0;
         if (w_accept) begin
            r_gnt  <= w_gnt;
            r_base <= w_base;
            r_ctx  <= w_ctx;
            r_tag  <= w_tag;
            r_ptr  <= w_nptr;
         end
         if (r_state == ST_RESP) r_idx <= r_idx + 32'd1;
      end
   end

   // req_ready is a Mealy output; masking with rst_n keeps it low while reset is held
   assign req_ready        = (rst_n && w_accept) ? w_gnt : '0;
   assign submit_desc_base = r_base;
   assign submit_ring_mask = RING_MASK;
   assign context_sel      = r_ctx;
   assign submit_doorbell  = r_state == ST_RING;
   assign resp_valid       = (r_state == ST_RESP) ? r_gnt : '0;
   assign resp_status      = r_status;
   assign busy             = r_state != ST_IDLE;
   assign submit_idx       = r_idx;

endmodule

// File: tb/tb_cai_submit_sched.sv
// tb_cai_submit_sched: table-driven job vectors plus hand sequences for gating, late completion and reset
module tb_cai_submit_sched;

   localparam int NREQ = 2;
   localparam int TO   = 50;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    req_valid = '0;
   logic [1:0]    req_ready;
   logic [127:0]  req_desc_base = {64'h3000, 64'h2000};
   logic [31:0]   req_context = {16'h0101, 16'h0000};
   logic [63:0]   req_tag = '0;
   logic [63:0]   submit_desc_base;
   logic [31:0]   submit_ring_mask;
   logic [15:0]   context_sel;
   logic          submit_doorbell;
   logic          dev_ready = 1'b0;
   logic          comp_doorbell = 1'b0;
   logic [31:0]   comp_tag = '0;
   logic [15:0]   comp_status = '0;
   logic [1:0]    resp_valid;
   logic [15:0]   resp_status;
   logic          busy;
   logic [31:0]   submit_idx;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cai_submit_sched #(.NREQ(NREQ), .TIMEOUT_CYC(TO), .RING_MASK(32'd3)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_desc_base    (req_desc_base),
      .req_context      (req_context),
      .req_tag          (req_tag),
      .submit_desc_base (submit_desc_base),
      .submit_ring_mask (submit_ring_mask),
      .context_sel      (context_sel),
      .submit_doorbell  (submit_doorbell),
      .dev_ready        (dev_ready),
      .comp_doorbell    (comp_doorbell),
      .comp_tag         (comp_tag),
      .comp_status      (comp_status),
      .resp_valid       (resp_valid),
      .resp_status      (resp_status),
      .busy             (busy),
      .submit_idx       (submit_idx)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tagname);
      chk({tagname, "_ready"}, req_ready, 0);
      chk({tagname, "_base"}, submit_desc_base, 0);
      chk({tagname, "_mask"}, submit_ring_mask, 3);
      chk({tagname, "_ctx"}, context_sel, 0);
      chk({tagname, "_db"}, submit_doorbell, 0);
      chk({tagname, "_rv"}, resp_valid, 0);
      chk({tagname, "_rs"}, resp_status, 0);
      chk({tagname, "_busy"}, busy, 0);
      chk({tagname, "_idx"}, submit_idx, 0);
   endtask

   typedef struct {
      logic [1:0]  mask;
      logic [31:0] tag0;
      logic [31:0] tag1;
      int          d;
      logic [31:0] ctag;
      logic [15:0] cstat;
      logic [1:0]  gnt;
      logic [15:0] st;
      int          lat;
   } vec_t;

   vec_t v[10];

   initial begin
      int w, db, pulses, rl, bad;
      v[0] = '{2'b01, 32'd1, 32'd2, 10, 32'd1, 16'h0000, 2'b01, 16'h0000, 11};
      v[1] = '{2'b10, 32'd1, 32'd2,  4, 32'd2, 16'h0011, 2'b10, 16'h0011,  5};
      v[2] = '{2'b11, 32'd1, 32'd2,  1, 32'd1, 16'h0100, 2'b01, 16'h0100,  2};
      v[3] = '{2'b11, 32'd1, 32'd2,  2, 32'd2, 16'h0101, 2'b10, 16'h0101,  3};
      v[4] = '{2'b11, 32'd1, 32'd2,  5, 32'd1, 16'h0102, 2'b01, 16'h0102,  6};
      v[5] = '{2'b11, 32'd1, 32'd2,  7, 32'd2, 16'h0103, 2'b10, 16'h0103,  8};
      v[6] = '{2'b01, 32'd6, 32'd2,  3, 32'd5, 16'h1234, 2'b01, 16'hFFFE,  4};
      v[7] = '{2'b10, 32'd6, 32'd2,  2, 32'd2, 16'h0042, 2'b10, 16'h0042,  3};
      v[8] = '{2'b01, 32'd1, 32'd2, -1, 32'd0, 16'h0000, 2'b01, 16'hFFFF, 50};
      v[9] = '{2'b10, 32'd1, 32'd2, 49, 32'd2, 16'h0777, 2'b10, 16'h0777, 50};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("rst0");
      @(posedge clk); #1;
      rst_n = 1'b1;
      dev_ready = 1'b1;

      for (int k = 0; k < 10; k++) begin
         req_valid = v[k].mask;
         req_tag   = {v[k].tag1, v[k].tag0};
         dev_ready = 1'b1;
         w = 0;
         @(negedge clk);
         while (req_ready == 0 && w < 20) begin
            w++;
            @(negedge clk);
         end
         chk($sformatf("grant%0d", k), req_ready, v[k].gnt);
         chk($sformatf("idx%0d", k), submit_idx, k);
         db = 0;
         while (db < 6 && !submit_doorbell) begin
            db++;
            @(negedge clk);
         end
         chk($sformatf("db_lat%0d", k), db, 2);
         chk($sformatf("ctx%0d", k), context_sel, (v[k].gnt == 2'b01) ? 16'h0000 : 16'h0101);
         pulses = 1;
         rl = 0;
         for (int c = 1; c <= TO + 10 && rl == 0; c++) begin
            @(posedge clk); #1;
            if (k == 1) dev_ready = 1'b0;
            comp_tag      = v[k].ctag;
            comp_status   = v[k].cstat;
            comp_doorbell = (c == v[k].d);
            @(negedge clk);
            if (submit_doorbell) pulses++;
            if (resp_valid != 0) rl = c;
         end
         chk($sformatf("resp_lat%0d", k), rl, v[k].lat);
         chk($sformatf("resp_valid%0d", k), resp_valid, v[k].gnt);
         chk($sformatf("resp_status%0d", k), resp_status, v[k].st);
         chk($sformatf("db_pulses%0d", k), pulses, 1);
         chk($sformatf("base%0d", k), submit_desc_base, (v[k].gnt == 2'b01) ? 64'h2000 : 64'h3000);
         @(posedge clk); #1;
         comp_doorbell = 1'b0;
      end

      // late completion while idle must not start anything
      req_valid = '0;
      comp_doorbell = 1'b1;
      comp_tag = 32'd2;
      @(negedge clk);
      chk("idx_final", submit_idx, 10);
      bad = 0;
      repeat (5) begin
         @(posedge clk); #1;
         comp_doorbell = 1'b0;
         @(negedge clk);
         if (busy || resp_valid != 0) bad++;
      end
      chk("late_comp_ignored", bad, 0);
      chk("ctx_hold", context_sel, 16'h0101);

      // dev_ready low blocks grants
      dev_ready = 1'b0;
      req_valid = 2'b01;
      req_tag   = {32'd2, 32'd1};
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (req_ready != 0 || busy) bad++;
      end
      chk("gate_no_grant", bad, 0);
      @(posedge clk); #1;
      dev_ready = 1'b1;
      @(negedge clk);
      chk("gate_grant", req_ready, 2'b01);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("wait_busy", busy, 1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("rst_wait");
      bad = 0;
      repeat (3) begin
         @(posedge clk); #1;
         comp_doorbell = 1'b1;
         comp_tag = 32'd1;
         @(negedge clk);
         if (resp_valid != 0) bad++;
      end
      @(posedge clk); #1;
      comp_doorbell = 1'b0;
      req_valid = '0;
      rst_n = 1'b1;
      repeat (60) begin
         @(negedge clk);
         if (resp_valid != 0 || busy) bad++;
      end
      chk("dropped_job_no_resp", bad, 0);
      chk("idx_after_reset", submit_idx, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
